// File: rtl/ptr_sync_multi_if.sv
// rtl/ptr_sync_multi_if.sv - pointer synchroniser bus bundle
// The master drives the remote gray pointers and the error clear; the slave is the synchroniser.
interface ptr_sync_multi_if #(
  parameter int ptr_width = 8,
  parameter int NUM_CH    = 1
);
  localparam int PW1 = ptr_width + 1;

  logic [NUM_CH*PW1-1:0] ptr_gray_in;
  logic                  err_clr;
  logic [NUM_CH*PW1-1:0] ptr_sync_gray;
  logic [NUM_CH*PW1-1:0] ptr_sync_bin;
  logic [NUM_CH*PW1-1:0] ptr_delta;
  logic                  ptr_valid;
  logic [NUM_CH-1:0]     err_multibit;

  modport master (
    output ptr_gray_in,
    output err_clr,
    input  ptr_sync_gray,
    input  ptr_sync_bin,
    input  ptr_delta,
    input  ptr_valid,
    input  err_multibit
  );

  modport slave (
    input  ptr_gray_in,
    input  err_clr,
    output ptr_sync_gray,
    output ptr_sync_bin,
    output ptr_delta,
    output ptr_valid,
    output err_multibit
  );
endinterface

// File: rtl/ptr_sync_multi.sv
// rtl/ptr_sync_multi.sv - multi-channel gray pointer synchroniser with decode, delta and error flag
// Every output comes straight from a flop so nothing combinational crosses from the bus inputs.
module ptr_sync_multi #(
  parameter int ptr_width   = 8,
  parameter int SYNC_STAGES = 2,
  parameter int NUM_CH      = 1
) (
  input  logic              wclk,
  input  logic              w_rst,
  ptr_sync_multi_if.slave   bus
);

  localparam int PW1 = ptr_width + 1;
  localparam int W   = NUM_CH * PW1;
  localparam logic [2:0] WARM_LAST = 3'(SYNC_STAGES + 1);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
    $error("ptr_sync_multi: SYNC_STAGES must be in 2..4");
  end
  if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_ch
    $error("ptr_sync_multi: NUM_CH must be in 1..8");
  end

  typedef enum logic {
    WARMUP = 1'b0,
    RUN    = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;

  logic [W-1:0]      sync_q [SYNC_STAGES];
  logic [W-1:0]      sync_gray;
  logic [W-1:0]      prev_q;
  logic [W-1:0]      bin_q, bin_d;
  logic [W-1:0]      delta_q, delta_d;
  logic [NUM_CH-1:0] err_q, err_d;

  function automatic logic [PW1-1:0] gray2bin(input logic [PW1-1:0] g);
    logic [PW1-1:0] b;
    for (int i = 0; i < PW1; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

  assign sync_gray = sync_q[SYNC_STAGES-1];

  // Pure flop chain per bit: no logic may sit between stages.
  always_ff @(posedge wclk) begin
    if (w_rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      sync_q[0] <= bus.ptr_gray_in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      WARMUP: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_d == WARM_LAST) begin
          state_d = RUN;
        end
      end
      RUN: begin
        state_d = RUN;
      end
      default: begin
        state_d = WARMUP;
      end
    endcase
  end

  always_comb begin
    logic [PW1-1:0] g;
    logic [PW1-1:0] b;
    logic [PW1-1:0] diff;
    bin_d   = bin_q;
    delta_d = delta_q;
    err_d   = err_q;
    for (int c = 0; c < NUM_CH; c++) begin
      g    = sync_gray[c*PW1 +: PW1];
      b    = gray2bin(g);
      diff = g ^ prev_q[c*PW1 +: PW1];
      bin_d[c*PW1 +: PW1]   = b;
      delta_d[c*PW1 +: PW1] = b - bin_q[c*PW1 +: PW1];
      // More than one bit set in diff means a non-gray step; a set beats a coincident clear.
      if (state_q == RUN && (diff & (diff - 1'b1)) != '0) begin
        err_d[c] = 1'b1;
      end else if (bus.err_clr) begin
        err_d[c] = 1'b0;
      end
    end
  end

  always_ff @(posedge wclk) begin
    if (w_rst) begin
      state_q <= WARMUP;
      cnt_q   <= '0;
      prev_q  <= '0;
      bin_q   <= '0;
      delta_q <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prev_q  <= sync_gray;
      bin_q   <= bin_d;
      delta_q <= delta_d;
      err_q   <= err_d;
    end
  end

  assign bus.ptr_sync_gray = sync_gray;
  assign bus.ptr_sync_bin  = bin_q;
  assign bus.ptr_delta     = delta_q;
  assign bus.ptr_valid     = (state_q == RUN);
  assign bus.err_multibit  = err_q;

endmodule
